// File: rtl/fmc_pkg.sv
// Shared types for the FMC PSRAM slave request path: request entry and queue FSM states.
package fmc_pkg;

  localparam int unsigned FmcAddrWidth = 16;
  localparam int unsigned FmcDataWidth = 16;

  typedef struct packed {
    logic                    write;
    logic [FmcAddrWidth-1:0] addr;
    logic [FmcDataWidth-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } queue_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fmc_sync_fifo.sv
// Single-clock FIFO of req_t; head visible combinationally (0-cycle read), 1-cycle write.
// Push is refused while full even if a pop happens the same cycle.
module fmc_sync_fifo
  import fmc_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  req_t            push_dat,
  input  logic            pop,
  output req_t            pop_dat,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  req_t            mem [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_dat;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fmc_req_queue.sv
// In-order FMC request queue to a valid/ready register bus, one transaction outstanding; push->bus_valid_o 2 cycles,
// rvalid->rsp_valid_o 1 cycle; req_ready_o low while the FIFO is full. Define FMC_REQ_QUEUE_STATS_EN for drop/high-water stats.
module fmc_req_queue
  import fmc_pkg::*;
#(
  parameter int unsigned AddrWidth = FmcAddrWidth,
  parameter int unsigned DataWidth = FmcDataWidth,
  parameter int unsigned Depth     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 bus_valid_o,
  input  logic                 bus_ready_i,
  output logic                 bus_write_o,
  output logic [AddrWidth-1:0] bus_addr_o,
  output logic [DataWidth-1:0] bus_wdata_o,
  input  logic                 bus_rvalid_i,
  input  logic [DataWidth-1:0] bus_rdata_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o
`ifdef FMC_REQ_QUEUE_STATS_EN
  ,
  input  logic                   clr_stats_i,
  output logic [15:0]            drop_cnt_o,
  output logic [$clog2(Depth):0] hwm_o
`endif
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  queue_state_t    state_q;
  req_t            push_dat;
  req_t            head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            fifo_pop;

  assign push_dat    = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i};
  assign req_ready_o = !fifo_full;
  assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;

  fmc_sync_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (req_valid_i),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      bus_valid_o <= 1'b0;
      bus_write_o <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            bus_valid_o <= 1'b1;
            bus_write_o <= head.write;
            bus_addr_o  <= head.addr;
            bus_wdata_o <= head.wdata;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus_ready_i) begin
            bus_valid_o <= 1'b0;
            state_q     <= bus_write_o ? ST_IDLE : ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (bus_rvalid_i) begin
            rsp_rdata_o <= bus_rdata_i;
            rsp_valid_o <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FMC_REQ_QUEUE_STATS_EN
  logic drop;
  assign drop = req_valid_i && !req_ready_o;

  // Clear takes priority over a same-cycle drop or new high-water mark.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_stats_i) begin
      drop_cnt_o <= '0;
      hwm_o      <= '0;
    end else begin
      if (drop) drop_cnt_o <= sat_inc16(drop_cnt_o);
      if (fifo_count > hwm_o) hwm_o <= fifo_count;
    end
  end
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_fmc_req_queue.sv
// Directed bench for fmc_req_queue with a bus-side scoreboard and a simple read target.
module tb_fmc_req_queue;
  import fmc_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [15:0] req_addr_i = '0;
  logic [15:0] req_wdata_i = '0;
  logic        bus_valid_o;
  logic        bus_ready_i = 1'b1;
  logic        bus_write_o;
  logic [15:0] bus_addr_o;
  logic [15:0] bus_wdata_o;
  logic        bus_rvalid_i = 1'b0;
  logic [15:0] bus_rdata_i = '0;
  logic        rsp_valid_o;
  logic [15:0] rsp_rdata_o;
`ifdef FMC_REQ_QUEUE_STATS_EN
  logic        clr_stats_i = 1'b0;
  logic [15:0] drop_cnt_o;
  logic [3:0]  hwm_o;
`endif

  fmc_req_queue #(.AddrWidth(16), .DataWidth(16), .Depth(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .bus_valid_o  (bus_valid_o),
    .bus_ready_i  (bus_ready_i),
    .bus_write_o  (bus_write_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o)
`ifdef FMC_REQ_QUEUE_STATS_EN
    ,
    .clr_stats_i  (clr_stats_i),
    .drop_cnt_o   (drop_cnt_o),
    .hwm_o        (hwm_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  req_t        exp_q[$];
  logic [15:0] rsp_q[$];
  int          rd_lat = 3;
  logic [15:0] rd_val = '0;
  int          rv_cnt = 0;
  int          rv_cyc = -100;
  int          last_acc_cyc = -100;
  bit          stray = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Bus-side scoreboard: every accepted bus transfer and every response must match the next expectation.
  always @(negedge clk_i) begin
    req_t e;
    if (rst_ni && bus_valid_o && bus_ready_i) begin
      last_acc_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("bus_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("bus_write", bus_write_o, e.write);
        check("bus_addr", bus_addr_o, e.addr);
        if (e.write) check("bus_wdata", bus_wdata_o, e.wdata);
        else rv_cnt = rd_lat;
      end
    end
    if (rsp_valid_o) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        check("rsp_rdata", rsp_rdata_o, rsp_q.pop_front());
        check("rsp_after_rvalid", cyc, rv_cyc + 1);
      end
    end
  end

  // Read target: returns rd_val rd_lat cycles after a read is accepted.
  always @(posedge clk_i) begin
    #1;
    bus_rvalid_i = stray;
    bus_rdata_i  = stray ? 16'hDEAD : 16'h0000;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rd_val;
        rv_cyc       = cyc;
      end
    end
  end

  task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
    int t = 0;
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    @(negedge clk_i);
    while (!req_ready_o && t < 50) begin
      t++;
      @(negedge clk_i);
    end
    if (req_ready_o) exp_q.push_back('{write: w, addr: a, wdata: d});
    else check("push_timeout", 0, 1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0 || bus_valid_o) && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    check(tag, (exp_q.size() == 0 && rsp_q.size() == 0), 1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int k;
    int t;
    int rsp_cyc;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_bus_valid", bus_valid_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_bus_addr", bus_addr_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Single write: bus_valid_o exactly in cycle N+2, one cycle long
    push(1'b1, 16'h0012, 16'hBEEF);
    @(negedge clk_i); check("t1_n1_idle", bus_valid_o, 0);
    @(negedge clk_i); check("t1_n2_valid", bus_valid_o, 1);
    check("t1_addr", bus_addr_o, 16'h0012);
    check("t1_wdata", bus_wdata_o, 16'hBEEF);
    @(negedge clk_i); check("t1_n3_done", bus_valid_o, 0);
    check("t1_no_rsp", rsp_valid_o, 0);
    @(posedge clk_i); #1;

    // Single read, target answers 3 cycles after accept
    rd_lat = 3; rd_val = 16'h1234; rsp_q.push_back(16'h1234);
    push(1'b0, 16'h0040, 16'h0000);
    t = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && t < 30) begin t++; @(negedge clk_i); end
    rsp_cyc = cyc;
    check("t2_rsp_seen", rsp_valid_o, 1);
    check("t2_rsp_lat", rsp_cyc - last_acc_cyc, 4);
    @(negedge clk_i);
    check("t2_rsp_pulse", rsp_valid_o, 0);
    check("t2_rsp_hold", rsp_rdata_o, 16'h1234);
    drain("t2_drain", 20);

    // Fill with the bus stalled: 1 in the output regs + 8 in the FIFO, then stall
    bus_ready_i = 1'b0; k = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid_i = 1'b1; req_write_i = 1'b1;
      req_addr_i  = 16'h0100 + k[15:0];
      req_wdata_i = 16'hA000 + k[15:0];
      @(negedge clk_i);
      if (req_ready_o) begin
        exp_q.push_back('{write: 1'b1, addr: req_addr_i, wdata: req_wdata_i});
        k++;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("t3_accepted", k, 9);
    check("t3_full_ready", req_ready_o, 0);
    check("t3_hold_valid", bus_valid_o, 1);
    check("t3_hold_addr", bus_addr_o, 16'h0100);
`ifdef FMC_REQ_QUEUE_STATS_EN
    check("t6_drop_cnt", drop_cnt_o, 3);
    check("t6_hwm", hwm_o, 8);
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; clr_stats_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; clr_stats_i = 1'b0;
    @(negedge clk_i);
    check("t6_clr_wins_drop", drop_cnt_o, 0);
    check("t6_clr_hwm", hwm_o, 0);
    @(negedge clk_i);
    check("t6_hwm_refill", hwm_o, 8);
`endif
    @(posedge clk_i); #1;
    bus_ready_i = 1'b1;
    drain("t3_drain", 100);
`ifdef FMC_REQ_QUEUE_STATS_EN
    clr_stats_i = 1'b1;
    @(posedge clk_i); #1;
    clr_stats_i = 1'b0;
    @(negedge clk_i);
    check("t6_clr_drop", drop_cnt_o, 0);
    check("t6_clr_hwm_idle", hwm_o, 0);
    @(posedge clk_i); #1;
`endif

    // Write/read/write back-to-back: third waits for the read data
    rd_lat = 5; rd_val = 16'hC0DE; rsp_q.push_back(16'hC0DE);
    push(1'b1, 16'h0010, 16'h1111);
    push(1'b0, 16'h0010, 16'h0000);
    push(1'b1, 16'h0011, 16'h2222);
    drain("t4_drain", 60);
    check("t4_wr_after_rsp", (last_acc_cyc > rv_cyc), 1);

    // Reset while waiting on a slow read with 3 writes queued behind it
    rd_lat = 30; rd_val = 16'h5555; rsp_q.push_back(16'h5555);
    push(1'b0, 16'h0020, 16'h0000);
    push(1'b1, 16'h0021, 16'h0001);
    push(1'b1, 16'h0022, 16'h0002);
    push(1'b1, 16'h0023, 16'h0003);
    repeat (4) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    exp_q.delete(); rsp_q.delete(); rv_cnt = 0;
    @(negedge clk_i);
    check("t5_bus_valid", bus_valid_o, 0);
    check("t5_rsp_valid", rsp_valid_o, 0);
    check("t5_req_ready", req_ready_o, 1);
    stray = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("t5_stray_rsp", rsp_valid_o, 0);
      check("t5_stray_bus", bus_valid_o, 0);
    end
    @(posedge clk_i); #1;

    // Queue still works after the mid-operation reset
    rd_lat = 1; rd_val = 16'hA5A5; rsp_q.push_back(16'hA5A5);
    push(0, 16'h0077, 16'h0000);
    drain("t5_post_drain", 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
